requant_writeback_arbiter: RTL and testbench
============================================

// Module: requant_writeback_arbiter
// PURPOSE
//  Shares the single activation-memory write port among the SA_N requantize channels.
//  - Buffers each channel's int8 results (valid, row, col) in a small per-channel FIFO.
//  - Grants the write port round-robin and forms each address as base + row*stride + col.
//  - Sequences each layer's writeback as start -> run -> flush/drain -> done.
//  - Sits between the requantize controller outputs and the activation SRAM.
// PARAMETERS
//  SA_N        4   number of requantize channels (requesters)
//  MAX_N       64  max rows/cols of an output tile
//  N_BITS      $clog2(MAX_N)  row/col index width
//  FIFO_DEPTH  4   entries per channel FIFO; power of two, >=2
//  ADDR_W      16  activation memory address width
// PORTS
//  clk         in   1            clock
//  reset       in   1            asynchronous, active-low reset
//  start       in   1            pulse: begin layer; samples base_addr/row_stride
//  flush       in   1            pulse: no more results for this layer; drain
//  base_addr   in   ADDR_W       layer output base address
//  row_stride  in   ADDR_W       words per output row
//  in_valid    in   1 [SA_N]     channel result valid (no backpressure upstream)
//  in_row      in   N_BITS[SA_N] result row
//  in_col      in   N_BITS[SA_N] result col
//  in_data     in   int8_t[SA_N] requantized value
//  mem_we      out  1            write request (valid)
//  mem_ready   in   1            memory accepts write this cycle
//  mem_addr    out  ADDR_W       write address
//  mem_wdata   out  int8_t       write data
//  idle        out  1            state==IDLE
//  done        out  1            one-cycle pulse at end of drain
//  overflow    out  SA_N         sticky per-channel drop flag
//  stray       out  1            sticky: in_valid seen while IDLE
// BEHAVIOUR
//  Reset (async, reset==0):
//   - state=IDLE; all FIFOs empty; rr_ptr=0.
//   - mem_we=0, mem_addr=0, mem_wdata=0; done=0, overflow=0, stray=0; idle=1.
//  FSM:
//   - IDLE->RUN on start: latch base/stride; clear overflow and stray.
//   - RUN->DRAIN on flush. start while in RUN or DRAIN is ignored.
//   - DRAIN->IDLE when all FIFOs are empty and no write is pending (mem_we==0, or mem_we&&mem_ready
//     with all FIFOs already empty). done pulses in that same cycle; idle rises the next cycle.
//  Push:
//   - In RUN/DRAIN, in_valid pushes {row,col,data} into that channel's FIFO.
//   - Push to a full FIFO with no same-cycle pop: entry dropped, overflow[ch] set (sticky).
//   - Push and pop on a full FIFO in the same cycle: both succeed.
//   - in_valid in IDLE: entry dropped, stray set.
//  Output register:
//   - mem_we/mem_addr/mem_wdata are registered and stay stable while mem_we && !mem_ready.
//   - The register loads when empty or accepted (mem_ready) and some FIFO is non-empty.
//   - Latency: push at cycle t -> mem_we at t+2 when uncontended (FIFO write, then pop/grant).
//   - Full throughput of one write per cycle while mem_ready stays 1.
//  Arbitration:
//   - Round-robin from rr_ptr over non-empty FIFOs.
//   - After granting ch i: rr_ptr=(i+1) mod SA_N; otherwise rr_ptr holds.
//  Address:
//   - mem_addr = base + row*stride + col, computed at ADDR_W+N_BITS width, truncated to ADDR_W.
//   - Wrap-around is silent.
//  Reset mid-operation: everything returns to reset values; pending entries are lost.
// CONFIGURATION
//  WB_ARB_PERF_CNT_EN defined:
//   - Adds outputs stall_cycles[31:0] (mem_we && !mem_ready) and writes_done[31:0] (accepted writes).
//   - Both clear on start, saturate at max, reset to 0.
//  WB_ARB_PERF_CNT_EN undefined: these ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package wb_arb_pkg:
//   - wb_state_e {WB_IDLE, WB_RUN, WB_DRAIN}
//   - wb_entry_t struct {row, col, int8_t data}
//   - int8_t comes from sys_types.
//  Sub-module wb_channel_fifo (one per channel, generate loop): synchronous FIFO with push, pop,
//  full, empty, and head entry.
//  Arbiter, address MAC, and FSM live in the top module.
// TESTING
//  1 Single entry: start(base=0x100, stride=8); ch2 pushes row=1,col=3,data=-5 -> two cycles
//    later mem_we=1, addr=0x10B, wdata=-5.
//  2 Round-robin: all 4 channels push in one cycle, mem_ready=1 -> writes in order ch0,1,2,3 on
//    consecutive cycles; next burst starts from ch0 again.
//  3 Backpressure: mem_ready=0 for 10 cycles while ch0 pushes 6 entries (FIFO_DEPTH=4)
//    -> addr/data stable; overflow[0]=1; exactly 5 writes after release (4 FIFO + 1 reg).
//  4 Drain: flush with 3 entries pending -> done pulses once, on the cycle the last write is
//    accepted; idle=1 the next cycle.
//  5 Stray/async reset: in_valid in IDLE -> stray=1, no write. Assert reset mid-RUN -> all outputs
//    reset immediately, no writes after release.
//  6 Wrap: base=0xFFFF, stride=1, row=0, col=2 -> mem_addr=0x0001.

Source files
------------

// File: rtl/sys_types.sv
// Shared scalar types used across the accelerator datapath.
package sys_types;

  typedef logic signed [7:0] int8_t;

endpackage

// File: rtl/wb_arb_pkg.sv
// Types and sizing shared by the requantize writeback arbiter and its channel FIFOs.
package wb_arb_pkg;

  import sys_types::*;

  localparam int unsigned WB_MAX_N  = 64;
  localparam int unsigned WB_N_BITS = $clog2(WB_MAX_N);

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_DRAIN
  } wb_state_e;

  // One buffered requantize result.
  typedef struct packed {
    logic [WB_N_BITS-1:0] row;
    logic [WB_N_BITS-1:0] col;
    int8_t                data;
  } wb_entry_t;

endpackage

// File: rtl/wb_channel_fifo.sv
// Per-channel synchronous FIFO of writeback entries.
// Ports: clk, reset (async active-low), push/push_entry, pop,
//        head_c (entry at read pointer), full_c, empty_c.
// A push on a full FIFO only lands when a pop happens in the same cycle.
module wb_channel_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t push_entry,
  output wb_entry_t head_c,
  output logic      full_c,
  output logic      empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  // Extra pointer bit distinguishes full from empty.
  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop_c  = pop && !empty_c;
  assign do_push_c = push && (!full_c || do_pop_c);
  assign head_c    = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

endmodule

// File: rtl/requant_writeback_arbiter.sv
// Shares the activation-memory write port among SA_N requantize channels.
// Each channel result is buffered in its own FIFO, channels are granted
// round-robin, and the write address is base + row*stride + col.
// Ports:
//   clk, reset (async active-low)
//   start/flush pulses, base_addr, row_stride  - layer control
//   in_valid/in_row/in_col/in_data             - per-channel results
//   mem_we/mem_addr/mem_wdata, mem_ready       - registered write port
//   idle, done (combinational drain-complete), overflow, stray
// Option WB_ARB_PERF_CNT_EN adds stall_cycles and writes_done counters.
module requant_writeback_arbiter
  import sys_types::*;
  import wb_arb_pkg::*;
#(
  parameter int unsigned SA_N       = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    row_stride,
  input  logic [SA_N-1:0]      in_valid,
  input  logic [WB_N_BITS-1:0] in_row  [SA_N],
  input  logic [WB_N_BITS-1:0] in_col  [SA_N],
  input  int8_t                in_data [SA_N],
  output logic                 mem_we,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output int8_t                mem_wdata,
  output logic                 idle,
  output logic                 done,
  output logic [SA_N-1:0]      overflow,
  output logic                 stray
`ifdef WB_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          writes_done
`endif
);

  localparam int unsigned N_BITS = WB_N_BITS;
  localparam int unsigned MAC_W  = ADDR_W + N_BITS;
  localparam int unsigned RR_W   = $clog2(SA_N);

  wb_state_e          state;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  stride_q;
  logic [RR_W-1:0]    rr_ptr;

  wb_entry_t          head [SA_N];
  logic [SA_N-1:0]    fifo_full;
  logic [SA_N-1:0]    fifo_empty;
  logic [SA_N-1:0]    push_c;
  logic [SA_N-1:0]    pop_c;
  logic               grant_vld_c;
  logic [RR_W-1:0]    grant_c;
  logic               can_load_c;
  logic               load_c;
  logic [MAC_W-1:0]   addr_full_c;
  wb_entry_t          sel_c;

  // Results are only accepted while a layer is open.
  assign push_c = (state != WB_IDLE) ? in_valid : '0;

  for (genvar i = 0; i < SA_N; i++) begin : g_ch
    wb_entry_t in_entry;
    assign in_entry = '{row: in_row[i], col: in_col[i], data: in_data[i]};

    wb_channel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_c[i]),
      .pop        (pop_c[i]),
      .push_entry (in_entry),
      .head_c     (head[i]),
      .full_c     (fifo_full[i]),
      .empty_c    (fifo_empty[i])
    );
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = rr_ptr;
    for (int unsigned k = 0; k < SA_N; k++) begin
      if (!grant_vld_c && !fifo_empty[RR_W'((32'(rr_ptr) + k) % SA_N)]) begin
        grant_vld_c = 1'b1;
        grant_c     = RR_W'((32'(rr_ptr) + k) % SA_N);
      end
    end
  end

  // Output register is free when empty or being accepted this cycle.
  assign can_load_c  = !mem_we || mem_ready;
  assign load_c      = can_load_c && grant_vld_c;
  assign pop_c       = load_c ? (SA_N'(1) << grant_c) : '0;
  assign sel_c       = head[grant_c];
  assign addr_full_c = MAC_W'(base_q) + MAC_W'(sel_c.row) * MAC_W'(stride_q)
                     + MAC_W'(sel_c.col);

  // Drain completes in the cycle the last pending write leaves.
  assign done = (state == WB_DRAIN) && (&fifo_empty) && can_load_c;

  // Layer FSM, status flags and the registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WB_IDLE;
      idle      <= 1'b1;
      base_q    <= '0;
      stride_q  <= '0;
      rr_ptr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overflow  <= '0;
      stray     <= 1'b0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (start) begin
            state    <= WB_RUN;
            idle     <= 1'b0;
            base_q   <= base_addr;
            stride_q <= row_stride;
            overflow <= '0;
            stray    <= 1'b0;
          end
        end
        WB_RUN: begin
          if (flush) state <= WB_DRAIN;
        end
        WB_DRAIN: begin
          if (done) begin
            state <= WB_IDLE;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= WB_IDLE;
          idle  <= 1'b1;
        end
      endcase

      // A stray result in the same cycle as start still flags.
      if (state == WB_IDLE && |in_valid) stray <= 1'b1;

      for (int unsigned i = 0; i < SA_N; i++) begin
        if (push_c[i] && fifo_full[i] && !pop_c[i]) overflow[i] <= 1'b1;
      end

      if (can_load_c) begin
        mem_we <= grant_vld_c;
        if (grant_vld_c) begin
          mem_addr  <= addr_full_c[ADDR_W-1:0];
          mem_wdata <= sel_c.data;
          rr_ptr    <= RR_W'((32'(grant_c) + 1) % SA_N);
        end
      end
    end
  end

`ifdef WB_ARB_PERF_CNT_EN
  // Saturating stall and accepted-write counters, cleared on layer start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      writes_done  <= '0;
    end else if (state == WB_IDLE && start) begin
      stall_cycles <= '0;
      writes_done  <= '0;
    end else begin
      if (mem_we && !mem_ready && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (mem_we && mem_ready && writes_done != 32'hFFFF_FFFF)
        writes_done <= writes_done + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_requant_writeback_arbiter.sv
// Directed and randomized bench for requant_writeback_arbiter with a
// queue-based reference model of the channel buffers and write port.
module tb_requant_writeback_arbiter;

  import sys_types::*;
  import wb_arb_pkg::*;

  localparam int SA_N  = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] row_stride = '0;
  logic [3:0]  in_valid = '0;
  logic [5:0]  in_row [SA_N];
  logic [5:0]  in_col [SA_N];
  int8_t       in_data [SA_N];
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr;
  int8_t       mem_wdata;
  logic        idle;
  logic        done;
  logic [3:0]  overflow;
  logic        stray;
`ifdef WB_ARB_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] writes_done;
`endif

  requant_writeback_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .flush      (flush),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .in_valid   (in_valid),
    .in_row     (in_row),
    .in_col     (in_col),
    .in_data    (in_data),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .idle       (idle),
    .done       (done),
    .overflow   (overflow),
    .stray      (stray)
`ifdef WB_ARB_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .writes_done  (writes_done)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: per-channel queues plus one output slot.
  typedef struct {
    int row;
    int col;
    int data;
  } ent_t;

  ent_t     mq [SA_N][$];
  int       m_phase;   // 0 idle, 1 collecting, 2 draining
  int       m_base, m_stride, m_rr;
  bit       m_we;
  int       m_addr, m_data;
  bit [3:0] m_ovf;
  bit       m_stray;

  function automatic void model_reset();
    for (int c = 0; c < SA_N; c++) mq[c].delete();
    m_phase = 0; m_base = 0; m_stride = 0; m_rr = 0;
    m_we = 0; m_addr = 0; m_data = 0; m_ovf = '0; m_stray = 0;
  endfunction

  function automatic bit model_done();
    bit empty_all = 1;
    for (int c = 0; c < SA_N; c++) if (mq[c].size() != 0) empty_all = 0;
    return (m_phase == 2) && empty_all && (!m_we || mem_ready);
  endfunction

  function automatic void model_step();
    int   ph = m_phase;
    bit   fin = model_done();
    int   g = -1;
    ent_t e;
    if (!m_we || mem_ready) begin
      for (int k = 0; k < SA_N; k++)
        if (g < 0 && mq[(m_rr + k) % SA_N].size() > 0) g = (m_rr + k) % SA_N;
      if (g >= 0) begin
        e = mq[g].pop_front();
        m_we = 1;
        m_addr = (m_base + e.row * m_stride + e.col) & 32'hFFFF;
        m_data = e.data;
        m_rr = (g + 1) % SA_N;
      end else begin
        m_we = 0;
      end
    end
    if (ph == 0 && start) begin
      m_phase = 1; m_base = int'(base_addr); m_stride = int'(row_stride);
      m_ovf = '0; m_stray = 0;
    end else if (ph == 1 && flush) begin
      m_phase = 2;
    end else if (ph == 2 && fin) begin
      m_phase = 0;
    end
    for (int c = 0; c < SA_N; c++) begin
      if (in_valid[c]) begin
        if (ph == 0) m_stray = 1;
        else if (mq[c].size() < DEPTH) begin
          e.row = int'(in_row[c]); e.col = int'(in_col[c]); e.data = int'(in_data[c]);
          mq[c].push_back(e);
        end else m_ovf[c] = 1;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("mem_we", {31'b0, mem_we}, {31'b0, m_we});
    if (m_we) begin
      chk("mem_addr", {16'b0, mem_addr}, m_addr & 32'hFFFF);
      chk("mem_wdata", {24'b0, mem_wdata}, m_data & 32'hFF);
    end
    chk("done", {31'b0, done}, {31'b0, model_done()});
    chk("idle", {31'b0, idle}, (m_phase == 0) ? 32'd1 : 32'd0);
    chk("overflow", {28'b0, overflow}, {28'b0, m_ovf});
    chk("stray", {31'b0, stray}, {31'b0, m_stray});
  endtask

  // One clock: compare at negedge, advance model at posedge, drive after.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; in_valid = '0; start = 1'b0; flush = 1'b0;
    #2;
    model_reset();
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    chk("rst_idle", {31'b0, idle}, 32'd1);
    chk("rst_flags", {27'b0, overflow, stray}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic begin_layer(input logic [15:0] b, input logic [15:0] s);
    base_addr = b; row_stride = s; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic set_ch(input int c, input int r, input int cl, input int d);
    in_row[c] = 6'(r); in_col[c] = 6'(cl); in_data[c] = 8'(d);
  endtask

  int w, dones, layer_cycles;
  bit seen_done;

  initial begin
    for (int c = 0; c < SA_N; c++) set_ch(c, 0, 0, 0);
    model_reset();
    #12;
    apply_reset();

    // Single entry latency and address.
    mem_ready = 1'b1;
    begin_layer(16'h0100, 16'd8);
    set_ch(2, 1, 3, -5); in_valid = 4'b0100;
    cycle();
    in_valid = '0;
    chk("t1_we_t1", {31'b0, mem_we}, 32'd0);
    cycle();
    chk("t1_we_t2", {31'b0, mem_we}, 32'd1);
    chk("t1_addr", {16'b0, mem_addr}, 32'h010B);
    chk("t1_wdata", {24'b0, mem_wdata}, 32'h00FB);
    cycle();
    chk("t1_we_after", {31'b0, mem_we}, 32'd0);

    // Round-robin over two bursts.
    apply_reset();
    mem_ready = 1'b1;
    begin_layer(16'h0000, 16'd16);
    for (int c = 0; c < SA_N; c++) set_ch(c, c, c, 10 + c);
    in_valid = 4'hF;
    cycle();
    in_valid = '0;
    for (int k = 0; k < SA_N; k++) begin
      if (k == SA_N - 1) begin
        for (int c = 0; c < SA_N; c++) set_ch(c, c, 1, 20 + c);
        in_valid = 4'hF;
      end
      cycle();
      in_valid = '0;
      chk("t2_burst1", {24'b0, mem_wdata}, 32'(10 + k));
    end
    for (int k = 0; k < SA_N; k++) begin
      cycle();
      chk("t2_burst2", {24'b0, mem_wdata}, 32'(20 + k));
    end
    cycle();

    // Backpressure with overflow on channel 0.
    apply_reset();
    mem_ready = 1'b0;
    begin_layer(16'h0200, 16'd4);
    for (int i = 0; i < 6; i++) begin
      set_ch(0, i, i, i + 1); in_valid = 4'b0001;
      cycle();
    end
    in_valid = '0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t3_stall_addr", {16'b0, mem_addr}, 32'h0200);
    chk("t3_stall_data", {24'b0, mem_wdata}, 32'd1);
    chk("t3_overflow", {28'b0, overflow}, 32'd1);
    mem_ready = 1'b1;
    w = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_we) w++;
      cycle();
    end
    chk("t3_writes", 32'(w), 32'd5);

    // Drain with three pending entries.
    apply_reset();
    mem_ready = 1'b0;
    begin_layer(16'h0000, 16'd8);
    for (int i = 0; i < 3; i++) begin
      set_ch(1, i, 0, i); in_valid = 4'b0010;
      cycle();
    end
    in_valid = '0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    mem_ready = 1'b1;
    w = 0; dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_outputs();
      seen_done = done;
      if (mem_we && mem_ready) w++;
      if (done) begin
        dones++;
        chk("t4_done_on_accept", {31'b0, mem_we}, 32'd1);
      end
      @(posedge clk);
      model_step();
      #1;
      if (seen_done) chk("t4_idle_next", {31'b0, idle}, 32'd1);
    end
    chk("t4_done_count", 32'(dones), 32'd1);
    chk("t4_writes", 32'(w), 32'd3);

    // Stray result while idle, then reset in the middle of a layer.
    set_ch(3, 2, 2, 7); in_valid = 4'b1000;
    cycle();
    in_valid = '0;
    chk("t5_stray", {31'b0, stray}, 32'd1);
    cycle();
    chk("t5_no_write", {31'b0, mem_we}, 32'd0);
    mem_ready = 1'b0;
    begin_layer(16'h0040, 16'd2);
    for (int i = 0; i < 6; i++) begin
      set_ch(0, 1, i, i); in_valid = 4'b0001;
      cycle();
    end
    in_valid = '0;
    chk("t5_pre_rst_ovf", {28'b0, overflow}, 32'd1);
    chk("t5_pre_rst_we", {31'b0, mem_we}, 32'd1);
    apply_reset();
    mem_ready = 1'b1;
    w = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_we) w++;
      cycle();
    end
    chk("t5_no_writes_after_rst", 32'(w), 32'd0);

    // Address wrap-around.
    begin_layer(16'hFFFF, 16'd1);
    set_ch(3, 0, 2, 9); in_valid = 4'b1000;
    cycle();
    in_valid = '0;
    cycle();
    chk("t6_wrap_addr", {16'b0, mem_addr}, 32'h0001);
    cycle();

    // Randomized layers against the model.
    for (int layer = 0; layer < 3; layer++) begin
      begin_layer(16'($urandom), 16'($urandom_range(0, 300)));
      for (int i = 0; i < 250; i++) begin
        for (int c = 0; c < SA_N; c++) begin
          in_valid[c] = ($urandom_range(0, 99) < 35);
          set_ch(c, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 255));
        end
        mem_ready = ($urandom_range(0, 99) < 70);
        start = ($urandom_range(0, 99) < 3);
        base_addr = 16'($urandom);
        cycle();
      end
      in_valid = '0; start = 1'b0;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      layer_cycles = 0;
      while (!idle && layer_cycles < 200) begin
        mem_ready = ($urandom_range(0, 99) < 70);
        cycle();
        layer_cycles++;
      end
      chk("rand_drain_idle", {31'b0, idle}, 32'd1);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
